// File: rtl/instr_register_pipe_if.sv
// Bus bundle for instr_register_pipe: write request, read port, clear control and status.
// Optional div-by-zero status signals exist only when INSTR_REG_DIV0_FLAG_EN is defined.
interface instr_register_pipe_if #(
  parameter int OPERAND_WIDTH = 32,
  parameter int DEPTH         = 32
);
  localparam int W          = OPERAND_WIDTH;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int OCC_WIDTH  = $clog2(DEPTH + 1);
  localparam int RD_WIDTH   = 3 + 6 * W;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [2:0]            wr_opcode;
  logic signed [W-1:0]   wr_op_a;
  logic signed [W-1:0]   wr_op_b;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic [RD_WIDTH-1:0]   rd_data;
  logic                  rd_empty;
  logic                  clear;
  logic                  busy;
  logic [OCC_WIDTH-1:0]  occupancy;
`ifdef INSTR_REG_DIV0_FLAG_EN
  logic                  rd_div0;
  logic [15:0]           div0_count;
`endif

`ifdef INSTR_REG_DIV0_FLAG_EN
  modport slave (
    input  wr_valid, wr_addr, wr_opcode, wr_op_a, wr_op_b, rd_en, rd_addr, clear,
    output wr_ready, rd_valid, rd_data, rd_empty, busy, occupancy, rd_div0, div0_count
  );
  modport master (
    output wr_valid, wr_addr, wr_opcode, wr_op_a, wr_op_b, rd_en, rd_addr, clear,
    input  wr_ready, rd_valid, rd_data, rd_empty, busy, occupancy, rd_div0, div0_count
  );
`else
  modport slave (
    input  wr_valid, wr_addr, wr_opcode, wr_op_a, wr_op_b, rd_en, rd_addr, clear,
    output wr_ready, rd_valid, rd_data, rd_empty, busy, occupancy
  );
  modport master (
    output wr_valid, wr_addr, wr_opcode, wr_op_a, wr_op_b, rd_en, rd_addr, clear,
    input  wr_ready, rd_valid, rd_data, rd_empty, busy, occupancy
  );
`endif
endinterface

// File: rtl/instr_register_pipe.sv
// Parametrised instruction register: 2-stage ALU write pipeline, forwarding read port, sweep clear.
// Define INSTR_REG_DIV0_FLAG_EN to add per-entry div-by-zero flags and a saturating counter.
module instr_register_pipe #(
  parameter int OPERAND_WIDTH = 32,
  parameter int DEPTH         = 32,
  parameter int ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_register_pipe_if.slave bus
);
  localparam int W         = OPERAND_WIDTH;
  localparam int RW        = 2 * W;
  localparam int OCC_WIDTH = $clog2(DEPTH + 1);
  localparam int RD_WIDTH  = 3 + 3 * RW;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    OP_ZERO, OP_PASSA, OP_PASSB, OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_MOD
  } opcode_e;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  function automatic logic [RW-1:0] sext(input logic [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  sweep_en;
  logic                  rdy_q;
  logic                  wr_fire;

  logic                  s1_vld_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q;
  logic [2:0]            s1_opc_q;
  logic [W-1:0]          s1_a_q, s1_b_q;

  logic                  s2_vld_q;
  logic [ADDR_WIDTH-1:0] s2_addr_q;
  logic [2:0]            s2_opc_q;
  logic [W-1:0]          s2_a_q, s2_b_q;
  logic [RW-1:0]         s2_res_q;

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [OCC_WIDTH-1:0]  occ_q, occ_d;

  logic [2:0]            mem_opc_q [DEPTH];
  logic [W-1:0]          mem_a_q   [DEPTH];
  logic [W-1:0]          mem_b_q   [DEPTH];
  logic [RW-1:0]         mem_res_q [DEPTH];

  logic                  rd_valid_q;
  logic [RD_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                  rd_empty_q, rd_empty_d;

  logic signed [RW-1:0]  a_ext, b_ext, alu_res;
  logic                  s1_div0;

`ifdef INSTR_REG_DIV0_FLAG_EN
  logic                  s2_div0_q;
  logic [DEPTH-1:0]      mem_div0_q;
  logic                  rd_div0_q, rd_div0_d;
  logic [15:0]           div0_cnt_q;
`endif

  assign bus.wr_ready = rdy_q && (state_q == ST_IDLE);
  assign wr_fire      = bus.wr_valid && bus.wr_ready;

  // ALU sits on the S1 registers so S1 forwarding and the S2 result share one datapath.
  always_comb begin
    a_ext   = sext(s1_a_q);
    b_ext   = sext(s1_b_q);
    s1_div0 = ((s1_opc_q == OP_DIV) || (s1_opc_q == OP_MOD)) && (s1_b_q == '0);
    alu_res = '0;
    case (s1_opc_q)
      OP_PASSA: alu_res = a_ext;
      OP_PASSB: alu_res = b_ext;
      OP_ADD:   alu_res = a_ext + b_ext;
      OP_SUB:   alu_res = a_ext - b_ext;
      OP_MULT:  alu_res = a_ext * b_ext;
      OP_DIV:   if (s1_b_q != '0) alu_res = a_ext / b_ext;
      OP_MOD:   if (s1_b_q != '0) alu_res = a_ext % b_ext;
      default:  alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_q    <= 1'b0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      rdy_q    <= 1'b1;
      s1_vld_q <= wr_fire;
      s2_vld_q <= s1_vld_q;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      s1_addr_q <= bus.wr_addr;
      s1_opc_q  <= bus.wr_opcode;
      s1_a_q    <= bus.wr_op_a;
      s1_b_q    <= bus.wr_op_b;
    end
    if (s1_vld_q) begin
      s2_addr_q <= s1_addr_q;
      s2_opc_q  <= s1_opc_q;
      s2_a_q    <= s1_a_q;
      s2_b_q    <= s1_b_q;
      s2_res_q  <= alu_res;
`ifdef INSTR_REG_DIV0_FLAG_EN
      s2_div0_q <= s1_div0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (s2_vld_q) begin
      mem_opc_q[s2_addr_q] <= s2_opc_q;
      mem_a_q[s2_addr_q]   <= s2_a_q;
      mem_b_q[s2_addr_q]   <= s2_b_q;
      mem_res_q[s2_addr_q] <= s2_res_q;
`ifdef INSTR_REG_DIV0_FLAG_EN
      mem_div0_q[s2_addr_q] <= s2_div0_q;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sweep_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.clear) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        sweep_en = 1'b1;
        if (idx_q == LAST_IDX) state_d = ST_IDLE;
        else                   idx_d   = idx_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // A drain landing on the index being swept this cycle is cleared: the sweep has not passed it.
  always_comb begin
    valid_d = valid_q;
    occ_d   = occ_q;
    if (s2_vld_q) valid_d[s2_addr_q] = 1'b1;
    if (sweep_en) valid_d[idx_q] = 1'b0;
    if (s2_vld_q && !valid_q[s2_addr_q] && !(sweep_en && (idx_q == s2_addr_q)))
      occ_d = occ_d + OCC_WIDTH'(1);
    if (sweep_en && valid_q[idx_q])
      occ_d = occ_d - OCC_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  always_comb begin
    rd_data_d  = '0;
    rd_empty_d = 1'b0;
`ifdef INSTR_REG_DIV0_FLAG_EN
    rd_div0_d  = 1'b0;
`endif
    if (s1_vld_q && (s1_addr_q == bus.rd_addr)) begin
      rd_data_d = {s1_opc_q, sext(s1_a_q), sext(s1_b_q), alu_res};
`ifdef INSTR_REG_DIV0_FLAG_EN
      rd_div0_d = s1_div0;
`endif
    end else if (s2_vld_q && (s2_addr_q == bus.rd_addr)) begin
      rd_data_d = {s2_opc_q, sext(s2_a_q), sext(s2_b_q), s2_res_q};
`ifdef INSTR_REG_DIV0_FLAG_EN
      rd_div0_d = s2_div0_q;
`endif
    end else if (valid_q[bus.rd_addr]) begin
      rd_data_d = {mem_opc_q[bus.rd_addr], sext(mem_a_q[bus.rd_addr]),
                   sext(mem_b_q[bus.rd_addr]), mem_res_q[bus.rd_addr]};
`ifdef INSTR_REG_DIV0_FLAG_EN
      rd_div0_d = mem_div0_q[bus.rd_addr];
`endif
    end else begin
      rd_empty_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_empty_q <= 1'b0;
`ifdef INSTR_REG_DIV0_FLAG_EN
      rd_div0_q  <= 1'b0;
`endif
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_q  <= rd_data_d;
        rd_empty_q <= rd_empty_d;
`ifdef INSTR_REG_DIV0_FLAG_EN
        rd_div0_q  <= rd_div0_d;
`endif
      end
    end
  end

`ifdef INSTR_REG_DIV0_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset)                                        div0_cnt_q <= '0;
    else if (s2_vld_q && s2_div0_q && (div0_cnt_q != '1)) div0_cnt_q <= div0_cnt_q + 16'd1;
  end

  assign bus.rd_div0    = rd_div0_q;
  assign bus.div0_count = div0_cnt_q;
`endif

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_empty  = rd_empty_q;
  assign bus.busy      = (state_q == ST_CLEAR);
  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_instr_register_pipe.sv
// Directed self-checking bench for instr_register_pipe (W=32, DEPTH=32).
module tb_instr_register_pipe;
  localparam int W  = 32;
  localparam int RW = 64;
  localparam int RDW = 3 + 3 * RW;

  localparam logic [2:0] ZERO = 3'd0, PASSA = 3'd1, PASSB = 3'd2, ADD = 3'd3;
  localparam logic [2:0] SUB = 3'd4, MULT = 3'd5, DIV = 3'd6, MOD = 3'd7;
  localparam logic signed [W-1:0] SMIN = 32'sh8000_0000;
  localparam logic signed [W-1:0] SMAX = 32'sh7FFF_FFFF;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  instr_register_pipe_if #(.OPERAND_WIDTH(W), .DEPTH(32)) bus ();

  instr_register_pipe #(.OPERAND_WIDTH(W), .DEPTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [RDW-1:0] mkword(input logic [2:0] opc, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [RW-1:0] res);
    return {opc, {{W{a[W-1]}}, a}, {{W{b[W-1]}}, b}, res};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [2:0] opc,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = addr;
    bus.wr_opcode = opc;
    bus.wr_op_a   = a;
    bus.wr_op_b   = b;
    tick();
    bus.wr_valid  = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] addr);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    tick();
    bus.rd_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got=%b exp=0", bus.wr_ready); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
    checks++; if (bus.occupancy !== 6'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", bus.occupancy); end
    checks++; if (bus.rd_data !== '0 || bus.rd_empty !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_outputs data=%h empty=%b busy=%b exp=0/0/0", bus.rd_data, bus.rd_empty, bus.busy);
    end
    reset = 1'b0;
    tick();
    checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL post_reset_wr_ready got=%b exp=1", bus.wr_ready); end
  endtask

  task automatic test_mult_read();
    do_read(5'd4);
    checks++; if (bus.rd_empty !== 1'b1 || bus.rd_data !== '0) begin
      failures++; $display("FAIL empty_read empty=%b data=%h exp=1/0", bus.rd_empty, bus.rd_data);
    end
    do_write(5'd3, MULT, -32'sd7, 32'sd6);
    tick(); tick(); tick();
    do_read(5'd3);
    checks++; if (bus.rd_data !== mkword(MULT, -32'sd7, 32'sd6, -64'sd42)) begin
      failures++; $display("FAIL mult_word got=%h exp=%h", bus.rd_data, mkword(MULT, -32'sd7, 32'sd6, -64'sd42));
    end
    checks++; if (bus.rd_data[3*RW-1:2*RW] !== 64'hFFFF_FFFF_FFFF_FFF9) begin
      failures++; $display("FAIL mult_op_a got=%h exp=fffffffffffffff9", bus.rd_data[3*RW-1:2*RW]);
    end
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_empty !== 1'b0) begin
      failures++; $display("FAIL mult_flags valid=%b empty=%b exp=1/0", bus.rd_valid, bus.rd_empty);
    end
    checks++; if (bus.occupancy !== 6'd1) begin failures++; $display("FAIL mult_occ got=%0d exp=1", bus.occupancy); end
    tick();
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data[RW-1:0] !== -64'sd42) begin
      failures++; $display("FAIL rd_hold valid=%b res=%h exp=0/-42", bus.rd_valid, bus.rd_data[RW-1:0]);
    end
  endtask

  task automatic test_forwarding();
    do_write(5'd5, ADD, 32'sd10, 32'sd4);
    do_read(5'd5);
    checks++; if (bus.rd_data !== mkword(ADD, 32'sd10, 32'sd4, 64'sd14) || bus.rd_empty !== 1'b0) begin
      failures++; $display("FAIL fwd_s1 got=%h empty=%b exp=%h/0", bus.rd_data, bus.rd_empty, mkword(ADD, 32'sd10, 32'sd4, 64'sd14));
    end
    do_write(5'd7, PASSB, 32'sd3, -32'sd9);
    tick();
    do_read(5'd7);
    checks++; if (bus.rd_data !== mkword(PASSB, 32'sd3, -32'sd9, -64'sd9) || bus.rd_empty !== 1'b0) begin
      failures++; $display("FAIL fwd_s2 got=%h empty=%b exp=%h/0", bus.rd_data, bus.rd_empty, mkword(PASSB, 32'sd3, -32'sd9, -64'sd9));
    end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    do_write(5'd5, ADD, 32'sd1, 32'sd1);
    do_write(5'd5, SUB, 32'sd1, 32'sd1);
    do_read(5'd5);
    checks++; if (bus.rd_data !== mkword(SUB, 32'sd1, 32'sd1, 64'sd0)) begin
      failures++; $display("FAIL b2b_fwd got=%h exp=%h", bus.rd_data, mkword(SUB, 32'sd1, 32'sd1, 64'sd0));
    end
    tick(); tick();
    do_read(5'd5);
    checks++; if (bus.rd_data !== mkword(SUB, 32'sd1, 32'sd1, 64'sd0)) begin
      failures++; $display("FAIL b2b_array got=%h exp=%h", bus.rd_data, mkword(SUB, 32'sd1, 32'sd1, 64'sd0));
    end
    checks++; if (bus.occupancy !== 6'd3) begin failures++; $display("FAIL b2b_occ got=%0d exp=3", bus.occupancy); end
  endtask

  task automatic test_divmod();
    do_write(5'd8,  DIV,   -32'sd7, 32'sd2);
    do_write(5'd9,  MOD,   -32'sd7, 32'sd2);
    do_write(5'd10, DIV,   32'sd9,  32'sd0);
    do_write(5'd11, MULT,  SMIN,    SMIN);
    do_write(5'd12, SUB,   SMIN,    SMAX);
    do_write(5'd13, PASSA, -32'sd5, 32'sd3);
    do_write(5'd14, ZERO,  32'sd5,  32'sd5);
    tick(); tick();
    do_read(5'd8);
    checks++; if (bus.rd_data !== mkword(DIV, -32'sd7, 32'sd2, -64'sd3)) begin
      failures++; $display("FAIL div_neg got=%h exp=%h", bus.rd_data, mkword(DIV, -32'sd7, 32'sd2, -64'sd3));
    end
`ifdef INSTR_REG_DIV0_FLAG_EN
    checks++; if (bus.rd_div0 !== 1'b0) begin failures++; $display("FAIL div0_flag_clr got=%b exp=0", bus.rd_div0); end
`endif
    do_read(5'd9);
    checks++; if (bus.rd_data !== mkword(MOD, -32'sd7, 32'sd2, -64'sd1)) begin
      failures++; $display("FAIL mod_neg got=%h exp=%h", bus.rd_data, mkword(MOD, -32'sd7, 32'sd2, -64'sd1));
    end
    do_read(5'd10);
    checks++; if (bus.rd_data !== mkword(DIV, 32'sd9, 32'sd0, 64'sd0)) begin
      failures++; $display("FAIL div_zero got=%h exp=%h", bus.rd_data, mkword(DIV, 32'sd9, 32'sd0, 64'sd0));
    end
`ifdef INSTR_REG_DIV0_FLAG_EN
    checks++; if (bus.rd_div0 !== 1'b1) begin failures++; $display("FAIL div0_flag_set got=%b exp=1", bus.rd_div0); end
    checks++; if (bus.div0_count !== 16'd1) begin failures++; $display("FAIL div0_count got=%0d exp=1", bus.div0_count); end
`endif
    do_read(5'd11);
    checks++; if (bus.rd_data[RW-1:0] !== 64'h4000_0000_0000_0000) begin
      failures++; $display("FAIL mult_min got=%h exp=4000000000000000", bus.rd_data[RW-1:0]);
    end
    do_read(5'd12);
    checks++; if (bus.rd_data[RW-1:0] !== 64'hFFFF_FFFF_0000_0001) begin
      failures++; $display("FAIL sub_min got=%h exp=ffffffff00000001", bus.rd_data[RW-1:0]);
    end
    do_read(5'd13);
    checks++; if (bus.rd_data[RW-1:0] !== -64'sd5) begin
      failures++; $display("FAIL passa got=%h exp=%h", bus.rd_data[RW-1:0], -64'sd5);
    end
    do_read(5'd14);
    checks++; if (bus.rd_data[RW-1:0] !== 64'd0 || bus.occupancy !== 6'd10) begin
      failures++; $display("FAIL zero_occ res=%h occ=%0d exp=0/10", bus.rd_data[RW-1:0], bus.occupancy);
    end
  endtask

  task automatic test_fill_clear();
    int busy_cycles = 0;
    int ready_seen  = 0;
    for (int i = 0; i < 32; i++) do_write(5'(i), ADD, 32'(i), 32'sd1);
    tick(); tick();
    checks++; if (bus.occupancy !== 6'd32) begin failures++; $display("FAIL fill_occ got=%0d exp=32", bus.occupancy); end
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy === 1'b1) begin
        busy_cycles++;
        if (bus.wr_ready !== 1'b0) ready_seen++;
      end
      tick();
    end
    checks++; if (busy_cycles != 32) begin failures++; $display("FAIL clear_busy_len got=%0d exp=32", busy_cycles); end
    checks++; if (ready_seen != 0) begin failures++; $display("FAIL clear_wr_ready got=%0d cycles exp=0", ready_seen); end
    checks++; if (bus.occupancy !== 6'd0) begin failures++; $display("FAIL clear_occ got=%0d exp=0", bus.occupancy); end
    do_read(5'd0);
    checks++; if (bus.rd_empty !== 1'b1 || bus.rd_data !== '0) begin
      failures++; $display("FAIL clear_rd0 empty=%b data=%h exp=1/0", bus.rd_empty, bus.rd_data);
    end
    do_read(5'd31);
    checks++; if (bus.rd_empty !== 1'b1 || bus.rd_data !== '0) begin
      failures++; $display("FAIL clear_rd31 empty=%b data=%h exp=1/0", bus.rd_empty, bus.rd_data);
    end
  endtask

  task automatic test_reset_mid_clear();
    do_write(5'd12, ADD, 32'sd1, 32'sd2);
    tick(); tick();
    do_write(5'd20, ADD, 32'sd3, 32'sd4);
    bus.clear = 1'b1;
    do_write(5'd30, ADD, 32'sd5, 32'sd6);
    bus.clear = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (bus.busy !== 1'b1 || bus.occupancy !== 6'd3) begin
      failures++; $display("FAIL midclear busy=%b occ=%0d exp=1/3", bus.busy, bus.occupancy);
    end
    reset = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.occupancy !== 6'd0 || bus.wr_ready !== 1'b0) begin
      failures++; $display("FAIL midclear_reset busy=%b occ=%0d ready=%b exp=0/0/0", bus.busy, bus.occupancy, bus.wr_ready);
    end
    reset = 1'b0;
    do_read(5'd20);
    checks++; if (bus.rd_empty !== 1'b1) begin failures++; $display("FAIL midclear_rd20 empty=%b exp=1", bus.rd_empty); end
    do_read(5'd30);
    checks++; if (bus.rd_empty !== 1'b1 || bus.wr_ready !== 1'b1) begin
      failures++; $display("FAIL midclear_rd30 empty=%b ready=%b exp=1/1", bus.rd_empty, bus.wr_ready);
    end
  endtask

  task automatic test_reset_pipe_full();
    do_write(5'd1, ADD, 32'sd2, 32'sd2);
    do_write(5'd2, ADD, 32'sd3, 32'sd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick();
    do_read(5'd1);
    checks++; if (bus.rd_empty !== 1'b1 || bus.rd_data !== '0) begin
      failures++; $display("FAIL pipe_reset_rd1 empty=%b data=%h exp=1/0", bus.rd_empty, bus.rd_data);
    end
    do_read(5'd2);
    checks++; if (bus.rd_empty !== 1'b1 || bus.occupancy !== 6'd0) begin
      failures++; $display("FAIL pipe_reset_rd2 empty=%b occ=%0d exp=1/0", bus.rd_empty, bus.occupancy);
    end
  endtask

  initial begin
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_opcode = '0;
    bus.wr_op_a   = '0;
    bus.wr_op_b   = '0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.clear     = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    test_reset();
    test_mult_read();
    test_forwarding();
    test_back_to_back();
    test_divmod();
    test_fill_clear();
    test_reset_mid_clear();
    test_reset_pipe_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/instr_register_pipe.md
Name: instr_register_pipe

Overview:
- Parametrised successor of the 32-entry instruction register.
- Configurable operand width and depth.
- Two-stage write pipeline with valid/ready handshake that computes and stores the ALU result on write.
- Registered read port with in-flight write forwarding, per-entry valid tracking, and a sequenced clear operation.
- Sits between the instruction-issue stimulus and downstream result consumers; the DUT for the next testbench generation.

Parameters:
- OPERAND_WIDTH, 32, signed operand width W; result width is 2W.
- DEPTH, 32, number of entries; power of two, at least 4.
- ADDR_WIDTH, $clog2(DEPTH), pointer width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  ADDR_WIDTH  write pointer.
- wr_opcode  in  3  ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
- wr_op_a  in  W  signed operand A.
- wr_op_b  in  W  signed operand B.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read pointer.
- rd_valid  out  1  rd_data valid, one cycle after rd_en.
- rd_data  out  3+2W+2W  {opc, op_a, op_b, result}; op_a/op_b sign-extended to 2W.
- rd_empty  out  1  addressed entry was never written since reset/clear.
- clear  in  1  pulse; invalidates all entries.
- busy  out  1  clear sequence in progress.
- occupancy  out  $clog2(DEPTH+1)  count of valid entries.

Behaviour:
- Reset:
  - Outputs: wr_ready=0 during the reset cycle and 1 the cycle after; rd_valid=0, rd_data=0, rd_empty=0, busy=0, occupancy=0.
  - Pipeline stages are emptied; all entry valid bits are cleared. Array contents need not be reset.
- Write pipeline:
  - S1 registers the accepted inputs.
  - S2 computes the result and writes it to the array at the end of S2.
  - An accepted write is visible in the array 2 cycles after acceptance. Throughput is 1 per cycle.
- Arithmetic (2W signed, operands sign-extended first):
  - ZERO gives 0; PASSA gives a; PASSB gives b.
  - ADD and SUB are 2W-wide with no overflow possible.
  - MULT is the full 2W product.
  - DIV truncates toward zero; MOD takes the sign of a.
  - b==0 makes DIV/MOD return 0.
- Read:
  - rd_en at cycle N gives rd_valid=1 with rd_data at N+1; otherwise rd_valid=0 and rd_data holds its last value.
- Forwarding: a read targets an address with a write in S1 or S2 in the same cycle.
  - rd_data returns the in-flight word. S1 beats S2, and both beat the array; the newest write wins.
  - rd_empty=0 in this case.
- Empty entry: a read of an invalid entry with no in-flight write returns rd_data=0 and rd_empty=1.
- Same-address back-to-back writes: the last accepted write wins.
- Occupancy:
  - Increments only when S2 writes an entry that was previously invalid.
  - Rewrites leave it unchanged.
- Clear FSM:
  - States IDLE and CLEAR.
  - IDLE → CLEAR when clear=1 in IDLE; clear is ignored when not in IDLE.
  - On entry, a sweep index starts at 0 and one valid bit is cleared per cycle.
  - CLEAR → IDLE after index DEPTH-1 is cleared, i.e. DEPTH cycles.
  - In CLEAR: busy=1, wr_ready=0.
  - Writes already in S1/S2 drain into the array, but their valid bits are cleared by the sweep only if the index has not yet passed their address.
  - Occupancy decrements for each valid bit cleared.
  - Reads during CLEAR are allowed and report current valid bits.
- Reset mid-operation: reset overrides everything, including in CLEAR and with the pipeline full; the FSM returns to IDLE.

Optional Feature:
- Macro: INSTR_REG_DIV0_FLAG_EN.
- Defined:
  - Adds output rd_div0 (1 bit), a per-entry flag set when DIV/MOD was written with b==0.
  - The flag is forwarded like rd_data and is 0 for empty entries.
  - Adds output div0_count (16 bits, saturating), incremented per div-by-zero write at S2 and cleared by reset.
- Undefined: neither port nor the per-entry storage exists; behaviour is otherwise identical.

Test Plan:
- Reset 2 cycles; check outputs:
  - During reset: wr_ready=0, rd_valid=0, occupancy=0.
  - The cycle after reset: wr_ready=1.
- Write addr 3 {MULT, a=-7, b=6}; read addr 3 four cycles later → rd_data result=-42, op_a=-7 sign-extended, rd_empty=0, occupancy=1.
- Write addr 5 {ADD, 10, 4}; same cycle+1, rd_en addr 5 → forwarded result 14. Also write addr 5 twice back-to-back (ADD 1,1 then SUB 1,1) and read 1 cycle later → result 0 from S1 forwarding.
- DIV -7/2 → -3; MOD -7/2 → -1; DIV 9/0 → 0 (rd_div0=1 and div0_count=1 when INSTR_REG_DIV0_FLAG_EN is defined).
- Fill all DEPTH=32 entries (occupancy=32); pulse clear → busy=1 for exactly 32 cycles, wr_ready=0. Then: occupancy=0; a read of any address → rd_empty=1, rd_data=0.
- Assert reset during CLEAR at sweep index 10 with 2 writes in flight → next cycle busy=0, occupancy=0, and all reads empty.
